// File: rtl/odo_round_key_sequencer.sv
// Steps the key ROM through every period and hands each period's key to the
// round datapath for ROUNDS_PER_PERIOD valid/ready transfers.
module odo_round_key_sequencer #(
    parameter int NUM_PERIODS       = 9,
    parameter int ROUNDS_PER_PERIOD = 4,
    parameter int ROM_LAT           = 1,
    parameter int KEY_W             = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       period,
    input  logic [KEY_W-1:0] rom_key,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [3:0]       key_period,
    output logic [7:0]       key_round,
    output logic             key_last
);

    localparam int WW = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
    localparam int RW = (ROUNDS_PER_PERIOD > 1) ? $clog2(ROUNDS_PER_PERIOD) : 1;
    localparam logic [WW-1:0] WAIT_LAST   = WW'(ROM_LAT);
    localparam logic [RW-1:0] RPP_LAST    = RW'(ROUNDS_PER_PERIOD - 1);
    localparam logic [3:0]    PERIOD_LAST = 4'(NUM_PERIODS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         period_reg, period_next;
    logic [WW-1:0]      wait_cnt_reg, wait_cnt_next;
    logic [RW-1:0]      rpp_cnt_reg, rpp_cnt_next;
    logic [KEY_W-1:0]   key_out_reg, key_out_next;
    logic               key_valid_reg, key_valid_next;
    logic [3:0]         key_period_reg, key_period_next;
    logic [7:0]         key_round_reg, key_round_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            period_reg     <= '0;
            wait_cnt_reg   <= '0;
            rpp_cnt_reg    <= '0;
            key_out_reg    <= '0;
            key_valid_reg  <= 1'b0;
            key_period_reg <= '0;
            key_round_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            period_reg     <= period_next;
            wait_cnt_reg   <= wait_cnt_next;
            rpp_cnt_reg    <= rpp_cnt_next;
            key_out_reg    <= key_out_next;
            key_valid_reg  <= key_valid_next;
            key_period_reg <= key_period_next;
            key_round_reg  <= key_round_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        period_next     = period_reg;
        wait_cnt_next   = wait_cnt_reg;
        rpp_cnt_next    = rpp_cnt_reg;
        key_out_next    = key_out_reg;
        key_valid_next  = key_valid_reg;
        key_period_next = key_period_reg;
        key_round_next  = key_round_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = FETCH;
                    period_next    = '0;
                    wait_cnt_next  = '0;
                    rpp_cnt_next   = '0;
                    key_round_next = '0;
                end
            end
            FETCH: begin
                // The ROM output becomes valid ROM_LAT edges after the period change.
                if (wait_cnt_reg == WAIT_LAST) begin
                    key_out_next    = rom_key;
                    key_period_next = period_reg;
                    key_valid_next  = 1'b1;
                    state_next      = PRESENT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            PRESENT: begin
                if (key_valid_reg && key_ready) begin
                    key_round_next = key_round_reg + 8'd1;
                    if (rpp_cnt_reg == RPP_LAST) begin
                        rpp_cnt_next   = '0;
                        key_valid_next = 1'b0;
                        if (period_reg == PERIOD_LAST) begin
                            state_next = DONE;
                        end else begin
                            period_next   = period_reg + 4'd1;
                            wait_cnt_next = '0;
                            state_next    = FETCH;
                        end
                    end else begin
                        rpp_cnt_next = rpp_cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                period_next    = '0;
                key_round_next = '0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign period     = period_reg;
    assign key_out    = key_out_reg;
    assign key_valid  = key_valid_reg;
    assign key_period = key_period_reg;
    assign key_round  = key_round_reg;
    assign key_last   = key_valid_reg && (period_reg == PERIOD_LAST) &&
                        (rpp_cnt_reg == RPP_LAST);

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Directed bench: two sequencers (ROM latency 1 and 2) fed by table-driven ROM
// models, with a per-instance scoreboard checked on every handshake transfer.
module tb_odo_round_key_sequencer;

    typedef struct {
        logic [9:0] key;
        logic [3:0] per;
        logic [7:0] rnd;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic       reset, start_a, key_ready_a, start_b, key_ready_b;
    logic       busy_a, done_a, key_valid_a, key_last_a;
    logic       busy_b, done_b, key_valid_b, key_last_b;
    logic [3:0] period_a, key_period_a, period_b, key_period_b;
    logic [7:0] key_round_a, key_round_b;
    logic [9:0] rom_key_a, key_out_a, rom_key_b, rom_stage_b, key_out_b;

    function automatic logic [9:0] rom_lookup(input logic [3:0] p);
        case (p)
            4'd0: return 10'h343;
            4'd1: return 10'h227;
            4'd2: return 10'h033;
            4'd3: return 10'h3ec;
            4'd4: return 10'h07b;
            4'd5: return 10'h357;
            4'd6: return 10'h18c;
            4'd7: return 10'h1d6;
            4'd8: return 10'h046;
            default: return 10'h000;
        endcase
    endfunction

    always @(posedge clk) rom_key_a <= rom_lookup(period_a);
    always @(posedge clk) begin
        rom_stage_b <= rom_lookup(period_b);
        rom_key_b   <= rom_stage_b;
    end

    odo_round_key_sequencer #(.NUM_PERIODS(9), .ROUNDS_PER_PERIOD(4), .ROM_LAT(1), .KEY_W(10)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .period(period_a), .rom_key(rom_key_a), .key_out(key_out_a),
        .key_valid(key_valid_a), .key_ready(key_ready_a), .key_period(key_period_a),
        .key_round(key_round_a), .key_last(key_last_a)
    );

    odo_round_key_sequencer #(.NUM_PERIODS(9), .ROUNDS_PER_PERIOD(4), .ROM_LAT(2), .KEY_W(10)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .period(period_b), .rom_key(rom_key_b), .key_out(key_out_b),
        .key_valid(key_valid_b), .key_ready(key_ready_b), .key_period(key_period_b),
        .key_round(key_round_b), .key_last(key_last_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int xfer_a = 0, xfer_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_seq(input bit which);
        exp_t e;
        for (int r = 0; r < 36; r++) begin
            e.key  = rom_lookup(4'(r / 4));
            e.per  = 4'(r / 4);
            e.rnd  = 8'(r);
            e.last = (r == 35);
            if (which) q_b.push_back(e);
            else       q_a.push_back(e);
        end
    endtask

    // Scoreboard: a transfer is sampled mid-cycle and completes on the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (key_valid_a === 1'b1 && key_ready_a === 1'b1) begin
            chk("a_sb_has_entry", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("a_key_out", key_out_a, e.key);
                chk("a_key_period", key_period_a, e.per);
                chk("a_key_round", key_round_a, e.rnd);
                chk("a_key_last", key_last_a, e.last);
                $display("xfer A round=%0d period=%0d key=%03h last=%0b",
                         key_round_a, key_period_a, key_out_a, key_last_a);
            end
            xfer_a++;
        end
        if (key_valid_b === 1'b1 && key_ready_b === 1'b1) begin
            chk("b_sb_has_entry", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_key_out", key_out_b, e.key);
                chk("b_key_period", key_period_b, e.per);
                chk("b_key_round", key_round_b, e.rnd);
                chk("b_key_last", key_last_b, e.last);
                $display("xfer B round=%0d period=%0d key=%03h last=%0b",
                         key_round_b, key_period_b, key_out_b, key_last_b);
            end
            xfer_b++;
        end
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input string tag, output int n);
        n = 0;
        while (n < 300 && done_a !== 1'b1) begin
            step();
            n++;
        end
        chk(tag, done_a, 1);
    endtask

    int n, start_cyc, g;

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        key_ready_a = 1'b0; key_ready_b = 1'b1;
        repeat (3) step();
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_period", period_a, 0);
        chk("rst_key_valid", key_valid_a, 0);
        chk("rst_key_out", key_out_a, 0);
        chk("rst_key_round", key_round_a, 0);
        chk("rst_key_last", key_last_a, 0);
        chk("rst_b_busy", busy_b, 0);
        reset = 1'b0;
        step();

        // Full sequence, ready held high
        key_ready_a = 1'b1;
        push_seq(1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_cyc = cyc;
        chk("t1_busy", busy_a, 1);
        chk("t1_valid_e0", key_valid_a, 0);
        step();
        chk("t1_valid_e1", key_valid_a, 0);
        step();
        chk("t1_valid_e2", key_valid_a, 1);
        chk("t1_first_key", key_out_a, 10'h343);
        chk("t1_first_round", key_round_a, 0);
        wait_done_a("t2_done_seen", n);
        chk("t2_done_edge", 32'(cyc - start_cyc), 54);
        step();
        chk("t2_busy_fall", busy_a, 0);
        chk("t2_done_pulse", done_a, 0);
        chk("t2_period_zero", period_a, 0);
        chk("t2_done_cnt", 32'(done_cnt_a), 1);
        chk("t1_xfer_cnt", 32'(xfer_a), 36);
        chk("t1_sb_empty", 32'(q_a.size()), 0);

        // Backpressure at key_round 5
        push_seq(1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (n < 100 && !(key_valid_a === 1'b1 && key_round_a == 8'd5)) begin
            step();
            n++;
        end
        chk("t3_reached_r5", key_round_a, 5);
        key_ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_valid", key_valid_a, 1);
            chk("t3_hold_key", key_out_a, 10'h227);
            chk("t3_hold_round", key_round_a, 5);
            chk("t3_hold_period", key_period_a, 1);
        end
        key_ready_a = 1'b1;
        wait_done_a("t3_done_seen", n);
        step();
        chk("t3_done_cnt", 32'(done_cnt_a), 2);
        chk("t3_xfer_cnt", 32'(xfer_a), 72);
        chk("t3_sb_empty", 32'(q_a.size()), 0);

        // Start pulsed while busy is ignored
        push_seq(1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (n < 100 && key_round_a != 8'd10) begin
            step();
            n++;
        end
        chk("t4_reached_r10", key_round_a, 10);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done_a("t4_done_seen", n);
        step();
        chk("t4_done_cnt", 32'(done_cnt_a), 3);
        chk("t4_xfer_cnt", 32'(xfer_a), 108);
        chk("t4_sb_empty", 32'(q_a.size()), 0);
        repeat (3) step();
        chk("t4_not_queued", busy_a, 0);

        // Reset in PRESENT at period 3
        push_seq(1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        n = 0;
        while (n < 100 && !(key_valid_a === 1'b1 && key_period_a == 4'd3)) begin
            step();
            n++;
        end
        chk("t5_reached_p3", key_period_a, 3);
        reset = 1'b1;
        key_ready_a = 1'b0;
        step();
        reset = 1'b0;
        chk("t5_busy", busy_a, 0);
        chk("t5_valid", key_valid_a, 0);
        chk("t5_period", period_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_round", key_round_a, 0);
        q_a.delete();
        key_ready_a = 1'b1;
        push_seq(1'b0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        chk("t5_restart_valid", key_valid_a, 1);
        chk("t5_restart_key", key_out_a, 10'h343);
        wait_done_a("t5_done_seen", n);
        step();
        chk("t5_done_cnt", 32'(done_cnt_a), 4);
        chk("t5_sb_empty", 32'(q_a.size()), 0);

        // ROM_LAT=2 instance
        push_seq(1'b1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        start_cyc = cyc;
        step();
        chk("t6_valid_e1", key_valid_b, 0);
        step();
        chk("t6_valid_e2", key_valid_b, 0);
        step();
        chk("t6_valid_e3", key_valid_b, 1);
        chk("t6_first_key", key_out_b, 10'h343);
        n = 0;
        while (n < 50 && key_valid_b === 1'b1) begin
            step();
            n++;
        end
        g = 0;
        while (g < 50 && key_valid_b !== 1'b1) begin
            step();
            g++;
        end
        chk("t6_gap", 32'(g), 3);
        chk("t6_second_key", key_out_b, 10'h227);
        n = 0;
        while (n < 300 && done_b !== 1'b1) begin
            step();
            n++;
        end
        chk("t6_done_seen", done_b, 1);
        chk("t6_done_edge", 32'(cyc - start_cyc), 63);
        step();
        chk("t6_busy_fall", busy_b, 0);
        chk("t6_done_cnt", 32'(done_cnt_b), 1);
        chk("t6_xfer_cnt", 32'(xfer_b), 36);
        chk("t6_sb_empty", 32'(q_b.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
